// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// ------------
// Buffered UART transmitter. Fabric producers push bytes through a
// valid/ready handshake into a small FIFO. A baud-rate state machine then
// serialises each byte LSB-first onto txd, which feeds the Nios II UART
// receive pin.
//
// Frame format:
//   default build             : 8N1 (start, 8 data, stop)          = 10 bits
//   UART_TX_PARITY_EN defined : 8E1 (start, 8 data, even parity,
//                               stop)                              = 11 bits
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate; bit period DIV = (CLK_HZ + BAUD/2) / BAUD cycles
//   FIFO_DEPTH  FIFO entries, power of two, at least 2
//
// Ports:
//   clk_clk      in   system clock, rising edge
//   reset_reset  in   asynchronous active-high reset
//   tx_data      in   byte to send, taken when tx_valid && tx_ready
//   tx_valid     in   producer has a byte
//   tx_ready     out  FIFO not full (registered)
//   txd          out  serial line, idles high (registered)
//   busy         out  frame on the line or FIFO non-empty (registered)
//   fifo_count   out  bytes held in the FIFO, excluding the shifter

module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Transmit state machine
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic push;
  logic pop;
  logic baud_last;
  logic fifo_nonempty;
  logic next_idle;

  assign fifo_count    = count;
  assign push          = tx_valid && tx_ready;
  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign fifo_nonempty = (count != '0);

  // The FSM consumes a byte either from IDLE or on the final stop-bit cycle,
  // the latter giving back-to-back frames with no idle gap. Because count is
  // registered, a byte pushed this cycle cannot be popped until the next.
  assign pop = fifo_nonempty &&
               ((state == IDLE) || ((state == STOP) && baud_last));

  // True when the FSM will sit in IDLE after this edge; drives busy.
  assign next_idle = ((state == IDLE) && !pop) ||
                     ((state == STOP) && baud_last && !pop);

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage array is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. tx_ready
  // and busy are registered from next-state values so they line up exactly
  // with the occupancy and FSM state seen after the edge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      tx_ready <= (count_next != COUNT_FULL);
      busy     <= !next_idle || (count_next != '0);
    end
  end

  // Bit-level transmitter. txd is registered from the current state, so the
  // line trails the state by one cycle; every bit still lasts exactly DIV
  // cycles because the baud counter clears on every state change. Reset
  // forces the line high immediately, abandoning any partial frame.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      txd        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            state      <= START;
          end
        end

        START: begin
          txd <= 1'b0;
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          txd <= shift[0];
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        // Even parity over the byte, captured when the shifter was loaded.
        PARITY: begin
          txd <= parity_bit;
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif

        STOP: begin
          txd <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^mem[rd_ptr];
`endif
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// ---------------
// Directed bench for uart_tx_fifo at CLK_HZ=1 MHz, BAUD=100 kHz (DIV=10),
// FIFO_DEPTH=16. A free-running reference receiver decodes txd into a queue
// of frames; the main sequence pushes bytes and compares received frames,
// timing and status outputs against hand-computed values.
// Compile with UART_TX_PARITY_EN defined to exercise 8E1 frames.

`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME  = 110;
`else
  localparam int FRAME  = 100;
`endif

  typedef struct packed {
    logic [31:0] fall;
    logic [7:0]  data;
    logic        start_bit;
    logic        par;
    logic        stop_bit;
  } frame_t;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;

  int         cyc;
  int         check_count;
  int         pass_count;
  int         fail_count;
  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .txd         (txd),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  // 10 ns clock; cyc numbers the rising edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference receiver: on each falling edge of txd, sample mid-bit and
  // record the frame together with the edge number on which txd fell.
  initial begin
    frame_t f;
    forever begin
      @(negedge txd);
      #2;
      f = '0;
      f.fall = cyc;
      repeat (DIV / 2) @(posedge clk);
      #2 f.start_bit = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        #2 f.data[i] = txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (DIV) @(posedge clk);
      #2 f.par = txd;
`endif
      repeat (DIV) @(posedge clk);
      #2 f.stop_bit = txd;
      rx_q.push_back(f);
    end
  end

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepClock(1);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic valid);
    tx_data  = data;
    tx_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Push one byte on the next edge and return that edge's number.
  task automatic pushByte(input logic [7:0] b, output int edge_no);
    applyStimulus(b, 1'b1);
    stepClock(1);
    applyStimulus(8'h00, 1'b0);
    edge_no = cyc;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 4 * FRAME) begin
      stepClock(1);
      n++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  // Wait (bounded) for the receiver to deliver a frame and check it.
  task automatic expectFrame(input string tag, input logic [7:0] expv,
                             input logic exp_par, output int fall);
    frame_t f;
    int     n = 0;
    while (rx_q.size() == 0 && n < 3 * FRAME) begin
      stepClock(1);
      n++;
    end
    checkOutput({tag, "_rx"}, rx_q.size() != 0, 1);
    fall = -1;
    if (rx_q.size() != 0) begin
      f    = rx_q.pop_front();
      fall = f.fall;
      checkOutput({tag, "_start"}, f.start_bit, 0);
      checkOutput({tag, "_data"}, f.data, expv);
      checkOutput({tag, "_stop"}, f.stop_bit, 1);
`ifdef UART_TX_PARITY_EN
      checkOutput({tag, "_parity"}, f.par, exp_par);
`endif
    end
  endtask

  initial begin
    int         k;
    int         k2;
    int         fall_a;
    int         fall_b;
    int         pushed;
    int         received;
    int         guard;
    logic [7:0] b;
    logic [7:0] e;
    frame_t     f;

    check_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    reset       = 1'b1;
    applyStimulus(8'h00, 1'b0);
    stepClock(2);

    // Reset values.
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", fifo_count, 0);
    reset = 1'b0;
    stepClock(2);

    // Single byte 0x55: pop at k+1, start bit at k+2, busy until k+101.
    pushByte(8'h55, k);
    checkOutput("single_count_k", fifo_count, 1);
    checkOutput("single_busy_k", busy, 1);
    checkOutput("single_txd_k", txd, 1);
    stepClock(1);
    checkOutput("single_count_k1", fifo_count, 0);
    checkOutput("single_txd_k1", txd, 1);
    stepClock(1);
    checkOutput("single_txd_k2", txd, 0);
    expectFrame("single", 8'h55, 1'b0, fall_a);
    checkOutput("single_latency", fall_a - k, 2);
    runTo(k + FRAME);
    checkOutput("single_busy_last", busy, 1);
    stepClock(1);
    checkOutput("single_busy_fall", busy, 0);
    checkOutput("single_txd_idle", txd, 1);

    // Back-to-back 0xA3, 0x0F: second start bit exactly one frame later.
    pushByte(8'hA3, k);
    checkOutput("b2b_count_k", fifo_count, 1);
    pushByte(8'h0F, k2);
    checkOutput("b2b_count_k1", fifo_count, 1);
    stepClock(1);
    checkOutput("b2b_count_k2", fifo_count, 1);
    expectFrame("b2b_a", 8'hA3, 1'b0, fall_a);
    expectFrame("b2b_b", 8'h0F, 1'b0, fall_b);
    checkOutput("b2b_latency", fall_a - k, 2);
    checkOutput("b2b_gap", fall_b - fall_a, FRAME);
    waitIdle("b2b");

    // Full boundary: 17 consecutive pushes, the first goes to the shifter.
    applyStimulus(8'h10, 1'b1);
    stepClock(1);
    k = cyc;
    for (int i = 1; i < 16; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b1);
      stepClock(1);
    end
    checkOutput("full_ready_15", tx_ready, 1);
    checkOutput("full_count_15", fifo_count, 15);
    applyStimulus(8'h20, 1'b1);
    stepClock(1);
    checkOutput("full_ready_16", tx_ready, 0);
    checkOutput("full_count_16", fifo_count, 16);
    applyStimulus(8'hEE, 1'b1);
    stepClock(1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("full_drop_count", fifo_count, 16);
    checkOutput("full_drop_ready", tx_ready, 0);
    runTo(k + FRAME);
    checkOutput("full_ready_before_pop", tx_ready, 0);
    stepClock(1);
    checkOutput("full_ready_after_pop", tx_ready, 1);
    checkOutput("full_count_after_pop", fifo_count, 15);
    for (int i = 0; i < 17; i++) begin
      e = 8'h10 + 8'(i);
      expectFrame($sformatf("full_%0d", i), e, ^e, fall_a);
    end
    waitIdle("full");
    checkOutput("full_no_extra", rx_q.size(), 0);

    // Reset mid-frame: abort a 0xFF frame at cycle 45 with 0x11 queued.
    pushByte(8'hFF, k);
    pushByte(8'h11, k2);
    runTo(k + 2 + 44);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_txd", txd, 1);
    checkOutput("rstmid_count", fifo_count, 0);
    stepClock(2);
    reset = 1'b0;
    stepClock(1);
    checkOutput("rstmid_ready", tx_ready, 1);
    checkOutput("rstmid_count_rel", fifo_count, 0);
    checkOutput("rstmid_busy", busy, 0);
    stepClock(FRAME);
    checkOutput("rstmid_txd_quiet", txd, 1);
    rx_q.delete();
    pushByte(8'h5A, k);
    expectFrame("rstmid_fresh", 8'h5A, 1'b0, fall_a);
    checkOutput("rstmid_latency", fall_a - k, 2);
    waitIdle("rstmid");

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones (parity 1), 0x03 has two (parity 0).
    pushByte(8'h07, k);
    pushByte(8'h03, k2);
    expectFrame("par_07", 8'h07, 1'b1, fall_a);
    expectFrame("par_03", 8'h03, 1'b0, fall_b);
    checkOutput("par_frame_len", fall_b - fall_a, 110);
    waitIdle("par");
`endif

    // 64 random bytes with random push gaps; pointers wrap several times.
    pushed   = 0;
    received = 0;
    guard    = 0;
    while (received < 64 && guard < 64 * FRAME + 1000) begin
      if (pushed < 64 && tx_ready && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b1);
        exp_q.push_back(b);
        pushed++;
      end else begin
        applyStimulus(8'h00, 1'b0);
      end
      stepClock(1);
      guard++;
      while (rx_q.size() != 0) begin
        f = rx_q.pop_front();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~f.data;
        checkOutput($sformatf("rand_data_%0d", received), f.data, e);
        checkOutput($sformatf("rand_stop_%0d", received), f.stop_bit, 1);
`ifdef UART_TX_PARITY_EN
        checkOutput($sformatf("rand_par_%0d", received), f.par, ^e);
`endif
        received++;
      end
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("rand_received", received, 64);
    waitIdle("rand");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
